// File: rtl/uart_tx_fifo.sv
// Generic circular FIFO: registered count and full flag, combinational head read.
// Latency: a write is visible at the head on the cycle after it is accepted.
// Backpressure: a write while full is ignored; the producer watches full.
module uart_tx_fifo_buf #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    output logic [W-1:0]             pop_dat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_nxt;
    logic          wr_acc;
    logic          rd_acc;

    // Acceptance looks only at the registered full flag, so a pop in the
    // same cycle never frees room for a write.
    assign wr_acc  = push && !full;
    assign rd_acc  = pop && (count != '0);
    assign pop_dat = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (wr_acc && !rd_acc)
            count_nxt = count + CW'(1);
        else if (!wr_acc && rd_acc)
            count_nxt = count - CW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + AW'(1);
            if (rd_acc)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wr_ptr] <= push_dat;
    end
endmodule

// Queued UART transmitter: FIFO buffered, configurable data width, parity and stop bits.
// Latency: a write captured at edge E0 into an idle empty block drives the start bit from E0+1.
// Backpressure: writes while tx_full are dropped and flagged by a one-cycle tx_overflow.
module uart_tx_fifo #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          tx_en,
    input  logic [DATA_W-1:0]             tx_data,
    output logic                          tx_full,
    output logic                          tx_busy,
    output logic                          tx_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          tx
);
    localparam int DIV      = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int STOP_LEN = STOP_BITS * DIV;
    localparam int CNT_W    = (STOP_LEN > 2) ? $clog2(STOP_LEN) : 1;
    localparam int BIT_W    = $clog2(DATA_W);

    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_LEN - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);

    if (DIV < 2) begin : g_bad_div
        $error("uart_tx_fifo: CLK_HZ/BAUD gives fewer than 2 cycles per bit");
    end
    if (DATA_W < 5 || DATA_W > 9 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
        $error("uart_tx_fifo: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    div_cnt;
    logic [BIT_W-1:0]    bit_cnt;
    logic [DATA_W-1:0]   shreg;
    logic                par_bit;
    logic [DATA_W-1:0]   head;
    logic                frame_end;
    logic                pop;

    uart_tx_fifo_buf #(
        .W     (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (tx_en),
        .push_dat (tx_data),
        .pop      (pop),
        .pop_dat  (head),
        .count    (fifo_count),
        .full     (tx_full)
    );

    // The last stop cycle doubles as the load point, so queued frames run back to back.
    assign frame_end = (state == ST_STOP) && (div_cnt == STOP_LAST);
    assign pop       = (fifo_count != '0) && ((state == ST_IDLE) || frame_end);
    assign tx_busy   = (state != ST_IDLE) || (fifo_count != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            tx_overflow <= 1'b0;
        else
            tx_overflow <= tx_en && tx_full;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            tx      <= 1'b1;
            div_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
        end else if (pop) begin
            state   <= ST_START;
            tx      <= 1'b0;
            div_cnt <= '0;
            shreg   <= head;
            par_bit <= (PARITY == 2) ? ~^head : ^head;
        end else begin
            case (state)
                ST_IDLE: begin
                    tx <= 1'b1;
                end
                ST_START: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        tx      <= shreg[0];
                        state   <= ST_DATA;
                    end else begin
                        div_cnt <= div_cnt + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            if (PARITY != 0) begin
                                tx    <= par_bit;
                                state <= ST_PARITY;
                            end else begin
                                tx    <= 1'b1;
                                state <= ST_STOP;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                            shreg   <= shreg >> 1;
                            tx      <= shreg[1];
                        end
                    end else begin
                        div_cnt <= div_cnt + CNT_W'(1);
                    end
                end
                ST_PARITY: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        tx      <= 1'b1;
                        state   <= ST_STOP;
                    end else begin
                        div_cnt <= div_cnt + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (frame_end) begin
                        div_cnt <= '0;
                        state   <= ST_IDLE;
                    end else begin
                        div_cnt <= div_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
